// File: rtl/reg_file_dumper.sv
// ---------------------------------------------------------------------------
// reg_file_dumper
//
// Debug readout engine for the core's register file. A start pulse in IDLE
// launches a dump that walks registers 0..NUM_REGS-1 through a combinational
// debug read port. The dump is streamed as bytes over a valid/ready link:
//   sync byte, 4 bytes per register (LSB first), XOR checksum of data bytes.
//
// Parameters:
//   NUM_REGS  - registers dumped, starting at index 0 (<= 2**ADDR_W)
//   ADDR_W    - register address width
//   SYNC_BYTE - first byte of every dump
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous, active-high reset
//   start     - single-cycle dump request, only honoured in IDLE
//   rd_addr   - register index presented to the debug read port
//   rd_data   - combinational read data for rd_addr
//   tx_data   - byte to transmit
//   tx_valid  - tx_data is valid
//   tx_ready  - sink accepts the byte (transfer when tx_valid && tx_ready)
//   busy      - dump in progress
//   done      - one-cycle pulse when the dump has finished
// ---------------------------------------------------------------------------
module reg_file_dumper #(
    parameter int         NUM_REGS  = 32,
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LOAD,
        SEND,
        CSUM,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        byte_cnt;
    logic [7:0]        checksum;
    logic [31:0]       shift;
    logic              xfer;
    logic              last_byte;
    logic              last_reg;

    assign xfer      = tx_valid && tx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign last_reg  = (idx == LAST_IDX);

    // The read port address follows idx directly, so it only moves when
    // idx increments (or is cleared on a new dump / reset).
    assign rd_addr = idx;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Transfer-dependent states only advance on a
    // completed handshake, which keeps tx_valid/tx_data stable while stalled.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = SYNC;
            SYNC: if (xfer) next_state = LOAD;
            LOAD: next_state = SEND;
            SEND: begin
                if (xfer && last_byte) begin
                    next_state = last_reg ? CSUM : LOAD;
                end
            end
            CSUM: if (xfer) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode, purely from registered state and datapath registers.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: ;
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                busy     = 1'b1;
            end
            LOAD: busy = 1'b1;
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift[7:0];
                busy     = 1'b1;
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = checksum;
                busy     = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: register index, byte counter, running checksum and the
    // shift register. rd_data is only captured in LOAD, which is the single
    // combinational input-to-state path.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            byte_cnt <= 2'd0;
            checksum <= 8'h00;
            shift    <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        byte_cnt <= 2'd0;
                        checksum <= 8'h00;
                    end
                end
                LOAD: begin
                    shift    <= rd_data;
                    byte_cnt <= 2'd0;
                end
                SEND: begin
                    if (xfer) begin
                        checksum <= checksum ^ shift[7:0];
                        shift    <= {8'h00, shift[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte && !last_reg) begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dumper.sv
// ---------------------------------------------------------------------------
// tb_reg_file_dumper
//
// Self-checking bench for reg_file_dumper. A behavioural register file
// drives rd_data; the expected byte stream is built directly from the
// register contents (sync, LSB-first words, XOR checksum) and compared with
// the bytes actually transferred. Also checks done timing, busy length,
// rd_addr sequencing, handshake stability, start filtering and reset abort.
// ---------------------------------------------------------------------------
module tb_reg_file_dumper;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int DUMP_BYTES = 4 * NUM_REGS + 2;
    localparam int DONE_CYCLE = 5 * NUM_REGS + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    logic [31:0] regs [NUM_REGS];
    logic [7:0]  got [$];
    logic [7:0]  expBytes [$];
    int          addrSeen [$];
    int          doneCycle;
    int          busyCycles;
    int          stallCycles;
    int          doneCount;
    int          checks = 0;
    int          passes = 0;

    reg_file_dumper #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Register file debug port: index 0 always reads as zero.
    assign rd_data = (rd_addr == '0) ? 32'h0 : regs[rd_addr];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Expected stream straight from the register contents.
    task automatic buildExpected();
        logic [7:0]  csum;
        logic [31:0] word;
        expBytes.delete();
        expBytes.push_back(8'hA5);
        csum = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            word = (k == 0) ? 32'h0 : regs[k];
            for (int b = 0; b < 4; b++) begin
                expBytes.push_back(word[8*b +: 8]);
                csum = csum ^ word[8*b +: 8];
            end
        end
        expBytes.push_back(csum);
    endtask

    // Runs one dump from a start pulse. Cycle n is the n-th cycle after the
    // edge that sampled start. mode 0: always ready, 1: random ready,
    // 2: three stall cycles on byte 2 of reg 7. startA/startB assert start
    // during those cycles; abortAt asserts reset during that cycle and returns.
    task automatic applyStimulus(input int mode, input int startA,
                                 input int startB, input int abortAt);
        bit                prevHeld;
        logic [7:0]        prevData;
        logic [ADDR_W-1:0] prevAddr;
        int                stallUsed;
        got.delete();
        addrSeen.delete();
        doneCycle   = -1;
        busyCycles  = 0;
        stallCycles = 0;
        doneCount   = 0;
        stallUsed   = 0;
        prevHeld    = 1'b0;
        prevData    = 8'h00;
        prevAddr    = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            if (prevHeld) begin
                checkOutput("hold_valid", 32'(tx_valid), 32'd1);
                checkOutput("hold_data", 32'(tx_data), 32'(prevData));
                checkOutput("hold_addr", 32'(rd_addr), 32'(prevAddr));
            end
            if (busy) begin
                busyCycles++;
                if (addrSeen.size() == 0 || addrSeen[$] != int'(rd_addr))
                    addrSeen.push_back(int'(rd_addr));
            end
            if (done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = cyc;
            end
            if (cyc == abortAt) begin
                tx_ready = 1'b1;
                start    = 1'b0;
                reset    = 1'b1;
                return;
            end
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (tx_valid && got.size() == 31 && stallUsed < 3) begin
                        tx_ready = 1'b0;
                        stallUsed++;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
            endcase
            if (tx_valid && !tx_ready) stallCycles++;
            prevHeld = tx_valid && !tx_ready;
            prevData = tx_data;
            prevAddr = rd_addr;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            start = (cyc == startA || cyc == startB);
            if (doneCycle >= 0 && cyc == doneCycle + 1) begin
                checkOutput("idle_after_done", 32'({busy, done, tx_valid}), 32'd0);
                start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("done_seen_before_timeout", 32'(doneCount), 32'd1);
    endtask

    task automatic verifyDump(input int expDone);
        checkOutput("byte_count", 32'(got.size()), 32'(DUMP_BYTES));
        for (int i = 0; i < DUMP_BYTES && i < got.size(); i++)
            checkOutput($sformatf("byte%0d", i), 32'(got[i]), 32'(expBytes[i]));
        checkOutput("done_cycle", 32'(doneCycle), 32'(expDone));
        checkOutput("done_pulses", 32'(doneCount), 32'd1);
        checkOutput("busy_cycles", 32'(busyCycles), 32'(expDone - 1));
        checkOutput("addr_count", 32'(addrSeen.size()), 32'(NUM_REGS));
        for (int i = 0; i < NUM_REGS && i < addrSeen.size(); i++)
            checkOutput($sformatf("addr%0d", i), 32'(addrSeen[i]), 32'(i));
    endtask

    task automatic clearRegs();
        for (int k = 0; k < NUM_REGS; k++) regs[k] = 32'h0;
    endtask

    task automatic randomRegs();
        for (int k = 0; k < NUM_REGS; k++) regs[k] = $urandom;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        clearRegs();

        // Reset values, then a quiet idle period.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_tx_valid", 32'(tx_valid), 32'd0);
        end

        // Single non-zero register.
        $display("[TB] single register dump");
        regs[5] = 32'h12345678;
        buildExpected();
        applyStimulus(0, -1, -1, -1);
        verifyDump(DONE_CYCLE);

        // Full pattern, checksum cancels to zero.
        $display("[TB] full pattern dump");
        for (int k = 0; k < NUM_REGS; k++) regs[k] = k * 32'h01010101;
        buildExpected();
        applyStimulus(0, -1, -1, -1);
        verifyDump(DONE_CYCLE);

        // Backpressure on byte 2 of reg 7.
        $display("[TB] backpressure dump");
        clearRegs();
        regs[5] = 32'h12345678;
        buildExpected();
        applyStimulus(2, -1, -1, -1);
        verifyDump(DONE_CYCLE + 3);
        checkOutput("stall_cycles", 32'(stallCycles), 32'd3);

        // Start during reg 10 and on the done cycle are ignored; a start in
        // the first idle cycle after done is accepted.
        $display("[TB] start while busy");
        randomRegs();
        buildExpected();
        applyStimulus(0, 2 + 5 * 10 + 2, DONE_CYCLE, -1);
        verifyDump(DONE_CYCLE);
        applyStimulus(0, -1, -1, -1);
        verifyDump(DONE_CYCLE);

        // Reset during SEND of reg 3, then a clean dump.
        $display("[TB] reset mid-operation");
        randomRegs();
        buildExpected();
        applyStimulus(0, -1, -1, 2 + 5 * 3 + 2);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("abort_tx_data", 32'(tx_data), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'({done, busy}), 32'd0);
        end
        applyStimulus(0, -1, -1, -1);
        verifyDump(DONE_CYCLE);

        // Random data under random backpressure.
        for (int r = 0; r < 3; r++) begin
            $display("[TB] random backpressure dump %0d", r);
            randomRegs();
            buildExpected();
            applyStimulus(1, -1, -1, -1);
            verifyDump(DONE_CYCLE + stallCycles);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_dumper.md
# reg_file_dumper

Debug readout engine for the single-cycle core's register file. On a start pulse it reads every architectural register through a dedicated combinational read port. It then streams the contents out as a byte stream with valid/ready handshaking: a sync byte, 4 bytes per register (LSB first), and a trailing XOR checksum. It sits between the register file's debug read port and a byte-wide transmitter such as a UART TX.

## Interface
- NUM_REGS, 32, number of registers dumped, starting at index 0; must be ≤ 2^ADDR_W
- ADDR_W, 5, register address width
- SYNC_BYTE, 8'hA5, first byte of every dump
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE
- rd_addr  output  ADDR_W  register index driven to the register file debug read port
- rd_data  input  32  combinational read data for rd_addr, valid in the same cycle; index 0 reads as 0
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  sink accepts the byte; a transfer occurs on an edge where tx_valid && tx_ready
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse at end of dump

## Operation
- States: IDLE, SYNC, LOAD, SEND, CSUM, DONE.
- IDLE:
  - busy=0, tx_valid=0.
  - On start=1, clear idx, byte counter and checksum, then go to SYNC.
- SYNC:
  - tx_valid=1, tx_data=SYNC_BYTE.
  - On transfer, go to LOAD.
- LOAD:
  - rd_addr=idx, tx_valid=0.
  - Capture rd_data into a 32-bit shift register, clear byte counter, go to SEND.
- SEND:
  - tx_valid=1, tx_data=shift[7:0].
  - On transfer: checksum ^= tx_data; shift >>= 8; byte counter +1.
  - After byte 3 transfers: if idx==NUM_REGS-1 go to CSUM, else idx+1 and go to LOAD.
- CSUM:
  - tx_valid=1, tx_data=checksum, the XOR of all 4·NUM_REGS data bytes (the sync byte is excluded).
  - On transfer, go to DONE.
- DONE:
  - done=1, busy=0, tx_valid=0 for exactly one cycle, then go to IDLE.
- busy=1 in SYNC, LOAD, SEND and CSUM.
- start is ignored in every state except IDLE.
- rd_addr holds idx in all states; it changes only when idx increments.
- Total bytes per dump: 4·NUM_REGS+2 (130 with defaults).

## Timing
- Reset values: tx_valid=0, tx_data=0, busy=0, done=0, rd_addr=0, state=IDLE, idx=0, checksum=0.
- Reset mid-dump: the next edge returns all outputs to reset values. There is no partial completion and no done pulse.
- All outputs are registered or decoded from registered state. The only combinational input-to-state path is rd_data→shift register in LOAD.
- Handshake rules:
  - Once tx_valid rises, tx_data and tx_valid hold steady until the transfer edge.
  - tx_valid never drops without a transfer, except on reset.
- Latency with tx_ready held at 1, counting from the edge where start is sampled:
  - SYNC occupies cycle 1.
  - Each register takes 5 cycles (LOAD + 4 SEND).
  - CSUM takes 1 cycle.
  - done is high in cycle 5·NUM_REGS+3 (163 with defaults).
  - busy is high for 5·NUM_REGS+2 cycles.
- Each cycle with tx_ready=0 while tx_valid=1 stretches the dump by exactly one cycle.
- A start pulse coincident with the done cycle is ignored. A start pulse in the first IDLE cycle after done is accepted.

## Test plan
- **Reset values:** apply reset for 2 cycles, start=0 → all outputs at reset values; no tx_valid for 20 cycles.
- **Single non-zero register:** reg file has reg[5]=32'h12345678, all others 0; tx_ready=1; pulse start → stream is A5, then 20 bytes of 00, then 78 56 34 12, then 104 bytes of 00, then checksum 08. done fires at cycle 163; busy is high for 162 cycles.
- **Full pattern:** reg[k]=k·32'h01010101 → bytes for reg k are k k k k; checksum 00. rd_addr steps 0..31 exactly once each.
- **Backpressure:** same as the single-register case, with tx_ready=0 for 3 cycles while byte 2 of reg 7 is presented → tx_data and rd_addr stay stable; byte order is unchanged; done fires at cycle 166.
- **Start while busy:** pulse start during reg 10 and again on the done cycle → no restart and no extra bytes. A start one cycle after done begins a new dump with A5.
- **Reset mid-operation:** assert reset during SEND of reg 3 → tx_valid=0 and busy=0 after the edge, no done pulse. A subsequent start produces a complete, correct 130-byte dump.
